// File: rtl/washer_pkg.sv
// Shared constants and width helpers for the washer plant model and its controller bench.
package washer_pkg;

  localparam int DEF_FILL_CYCLES  = 8;
  localparam int DEF_DRAIN_CYCLES = 8;
  localparam int DEF_WASH_CYCLES  = 16;
  localparam int DEF_SPIN_CYCLES  = 12;
  localparam int DEF_DET_CYCLES   = 4;

  // Level must hold values up to the larger of the fill and drain travel.
  function automatic int levelWidth(input int fillCycles, input int drainCycles);
    return $clog2((fillCycles > drainCycles) ? fillCycles : drainCycles) + 1;
  endfunction

  function automatic int timerWidth(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/washer_sat_timer.sv
// Saturating up-counter with synchronous clear; flags when the limit has been reached.
module washer_sat_timer
  import washer_pkg::*;
#(
  parameter int LIMIT = DEF_WASH_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int W = timerWidth(LIMIT);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_q, count_d;

  // Clear wins over enable so a dropped command always restarts the interval.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIM)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_max_o = (count_q == LIM);

endmodule

// File: rtl/washer_plant_model.sv
// Behavioural plant of a washing machine drum: water level, wash/spin/detergent
// timers and sticky fault detection, answering a controller with sensor flags.
module washer_plant_model
  import washer_pkg::*;
#(
  parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int WASH_CYCLES  = DEF_WASH_CYCLES,
  parameter int SPIN_CYCLES  = DEF_SPIN_CYCLES,
  parameter int DET_CYCLES   = DEF_DET_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic fill_valve_open,
  input  logic drain_valve_open,
  input  logic motor_active,
  input  logic door_locked,
  input  logic detergent_cycle,
  output logic water_filled,
  output logic water_drained,
  output logic detergent_added,
  output logic cycle_complete,
  output logic spin_complete,
  output logic [levelWidth(FILL_CYCLES, DRAIN_CYCLES)-1:0] level,
  output logic fault
);

  localparam int LW = levelWidth(FILL_CYCLES, DRAIN_CYCLES);
  localparam logic [LW-1:0] LMAX = LW'(FILL_CYCLES);
  localparam int STEP_INT = ((FILL_CYCLES / DRAIN_CYCLES) > 0) ? (FILL_CYCLES / DRAIN_CYCLES) : 1;
  localparam logic [LW-1:0] DRAIN_STEP = LW'(STEP_INT);

  logic [LW-1:0] level_q, level_d;
  logic filled_q, filled_d;
  logic drained_q, drained_d;
  logic cycleDone_q, cycleDone_d;
  logic spinDone_q, spinDone_d;
  logic dispensed_q, dispensed_d;
  logic fault_q, fault_d;

  logic fillOnly, drainOnly, bothOpen;
  logic washEn, spinEn, detEn;
  logic washAtMax, spinAtMax, detAtMax;

  assign fillOnly  = fill_valve_open & ~drain_valve_open;
  assign drainOnly = drain_valve_open & ~fill_valve_open;
  assign bothOpen  = fill_valve_open & drain_valve_open;

  // Timers qualify on the registered sensor flags, as a real controller would see them.
  assign washEn = motor_active & filled_q;
  assign spinEn = drain_valve_open & drained_q;
  assign detEn  = detergent_cycle & filled_q & ~fill_valve_open & ~drain_valve_open & ~motor_active;

  washer_sat_timer #(.LIMIT(WASH_CYCLES)) u_washTimer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (washEn),
    .clr_i    (~motor_active),
    .at_max_o (washAtMax)
  );

  washer_sat_timer #(.LIMIT(SPIN_CYCLES)) u_spinTimer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (spinEn),
    .clr_i    (~drain_valve_open),
    .at_max_o (spinAtMax)
  );

  washer_sat_timer #(.LIMIT(DET_CYCLES)) u_detTimer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (detEn),
    .clr_i    (~door_locked),
    .at_max_o (detAtMax)
  );

  always_comb begin
    level_d = level_q;
    if (fillOnly) begin
      level_d = (level_q >= LMAX) ? LMAX : level_q + LW'(1);
    end else if (drainOnly) begin
      level_d = (level_q > DRAIN_STEP) ? level_q - DRAIN_STEP : '0;
    end
  end

  // Sensor flags decode the pre-edge level, so they trail the level by one cycle.
  always_comb begin
    filled_d    = (level_q == LMAX);
    drained_d   = (level_q == '0);
    cycleDone_d = washAtMax & motor_active;
    spinDone_d  = spinAtMax & drain_valve_open;
    dispensed_d = door_locked & (dispensed_q | detAtMax);
    fault_d     = fault_q | bothOpen | (fill_valve_open & ~door_locked)
                | (motor_active & (level_q < LMAX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q     <= '0;
      filled_q    <= 1'b0;
      drained_q   <= 1'b1;
      cycleDone_q <= 1'b0;
      spinDone_q  <= 1'b0;
      dispensed_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      level_q     <= level_d;
      filled_q    <= filled_d;
      drained_q   <= drained_d;
      cycleDone_q <= cycleDone_d;
      spinDone_q  <= spinDone_d;
      dispensed_q <= dispensed_d;
      fault_q     <= fault_d;
    end
  end

  assign level           = level_q;
  assign water_filled    = filled_q;
  assign water_drained   = drained_q;
  assign cycle_complete  = cycleDone_q;
  assign spin_complete   = spinDone_q;
  assign detergent_added = dispensed_q | detAtMax;
  assign fault           = fault_q;

endmodule
